// File: rtl/shift_seq.sv
// Multi-cycle LSL/LSR/ASR/ROR unit built around a single 32-bit left barrel shifter.
// Right shifts bit-reverse around the shifter; ASR and ROR may need a second pass.
module shift_seq #(
   parameter int unsigned ZERO_SKIP = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] value,
   input  logic [4:0]  shcnt,
   output logic        ready,
   output logic        done,
   output logic [31:0] res
);

   typedef enum logic [1:0] {IDLE, P1, P2} state_t;
   typedef enum logic [1:0] {OP_LSL = 2'b00, OP_ASR = 2'b01, OP_ROR = 2'b10, OP_LSR = 2'b11} op_t;

   state_t      state, state_d;
   op_t         op_q;
   logic [31:0] value_q;
   logic [4:0]  cnt_q;
   logic [31:0] acc, acc_d;
   logic [31:0] res_d;
   logic        done_d;
   logic        load;

   logic [31:0] sh_in;
   logic [4:0]  sh_cnt;
   logic [31:0] sh_out;
   logic        one_pass;

   function automatic logic [31:0] rev32(input logic [31:0] x);
      logic [31:0] r;
      for (int unsigned i = 0; i < 32; i++) r[i] = x[31-i];
      return r;
   endfunction

   assign one_pass = (op_q == OP_LSL) || (op_q == OP_LSR) ||
                     ((op_q == OP_ASR) && (ZERO_SKIP != 0) && !value_q[31]);

   // Shifter operands come only from latched state, never from the live ports.
   always_comb begin
      sh_in  = value_q;
      sh_cnt = cnt_q;
      if (state == P1) begin
         if (op_q != OP_LSL) sh_in = rev32(value_q);
      end else if (state == P2) begin
         if (op_q == OP_ASR) begin
            sh_in = '1;
         end else begin
            sh_cnt = 5'd0 - cnt_q;
         end
      end
   end

   always_comb begin
      sh_out = sh_in;
      if (sh_cnt[0]) sh_out = {sh_out[30:0], 1'b0};
      if (sh_cnt[1]) sh_out = {sh_out[29:0], 2'b0};
      if (sh_cnt[2]) sh_out = {sh_out[27:0], 4'b0};
      if (sh_cnt[3]) sh_out = {sh_out[23:0], 8'b0};
      if (sh_cnt[4]) sh_out = {sh_out[15:0], 16'b0};
   end

   always_comb begin
      state_d = state;
      acc_d   = acc;
      res_d   = res;
      done_d  = 1'b0;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = P1;
            end
         end
         P1: begin
            if (one_pass) begin
               res_d   = (op_q == OP_LSL) ? sh_out : rev32(sh_out);
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               acc_d   = rev32(sh_out);
               state_d = P2;
            end
         end
         P2: begin
            // ASR: reversed left-shifted ones give the sign-fill mask for the top n bits.
            if (op_q == OP_ASR) begin
               res_d = acc | (value_q[31] ? ~rev32(sh_out) : '0);
            end else begin
               res_d = acc | sh_out;
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op_q    <= OP_LSL;
         value_q <= '0;
         cnt_q   <= '0;
         acc     <= '0;
         res     <= '0;
         done    <= 1'b0;
      end else begin
         state <= state_d;
         acc   <= acc_d;
         res   <= res_d;
         done  <= done_d;
         if (load) begin
            op_q    <= op_t'(op);
            value_q <= value;
            cnt_q   <= shcnt;
         end
      end
   end

   assign ready = (state == IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed corner cases plus randomized
// back-to-back operations compared against an arithmetic reference model.
module tb_shift_seq;

   localparam int unsigned ZS = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] value;
   logic [4:0]  shcnt;
   logic        ready;
   logic        done;
   logic [31:0] res;

   int checks = 0;
   int errors = 0;
   int exp_dones = 0;
   int seen_dones = 0;

   always #5 clk = ~clk;

   shift_seq #(.ZERO_SKIP(ZS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .value (value),
      .shcnt (shcnt),
      .ready (ready),
      .done  (done),
      .res   (res)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] v, input logic [4:0] n);
      int unsigned k;
      k = n;
      case (o)
         2'b00:   return v << k;
         2'b01:   return $signed(v) >>> k;
         2'b10:   return (k == 0) ? v : ((v >> k) | (v << (32 - k)));
         default: return v >> k;
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] v);
      if (o == 2'b10) return 3;
      if (o == 2'b01) return (ZS != 0 && !v[31]) ? 2 : 3;
      return 2;
   endfunction

   // res must only move on a done pulse or after reset.
   logic [31:0] held = '0;
   logic        rst_seen = 1'b0;
   always @(negedge clk) begin
      if (done === 1'b1) seen_dones++;
      if (done === 1'b1 || rst_seen) held = res;
      else check("res_hold", res, held);
      rst_seen = rst;
   end

   // Issues one op; returns #1 after the edge where done is seen (the done cycle).
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                         input logic [4:0] n, input logic [31:0] want, input int want_lat);
      int c;
      c = 0;
      while (!ready && c < 8) begin @(posedge clk); #1; c++; end
      check({tag, "_ready_in"}, 32'(ready), 32'd1);
      op = o; value = v; shcnt = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      exp_dones++;
      c = 1;
      check({tag, "_busy"}, 32'(ready), 32'd0);
      while (!done && c < 8) begin
         op = 2'($urandom); value = $urandom; shcnt = 5'($urandom);
         @(posedge clk); #1;
         c++;
      end
      check({tag, "_lat"}, 32'(c), 32'(want_lat));
      check({tag, "_res"}, res, want);
      check({tag, "_ready_done"}, 32'(ready), 32'd1);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] rv;
      logic [4:0]  rn;
      int c;
      rst = 1'b1; start = 1'b0; op = '0; value = '0; shcnt = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", res, 32'd0);

      run_op("lsl31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 2);
      run_op("lsl0", 2'b00, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 2);
      run_op("lsr4", 2'b11, 32'h8000_0000, 5'd4, 32'h0800_0000, 2);
      run_op("asr4", 2'b01, 32'h8000_0000, 5'd4, 32'hF800_0000, 3);
      run_op("asr31p", 2'b01, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, (ZS != 0) ? 2 : 3);
      run_op("asr31n", 2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 3);
      run_op("asr0", 2'b01, 32'h8765_4321, 5'd0, 32'h8765_4321, 3);
      run_op("ror8", 2'b10, 32'h1234_5678, 5'd8, 32'h7812_3456, 3);
      run_op("ror0", 2'b10, 32'h1234_5678, 5'd0, 32'h1234_5678, 3);
      run_op("ror1", 2'b10, 32'h0000_0001, 5'd1, 32'h8000_0000, 3);

      // Second start while busy must be ignored.
      op = 2'b01; value = 32'h8000_0000; shcnt = 5'd4; start = 1'b1;
      @(posedge clk); #1;
      exp_dones++;
      op = 2'b00; value = 32'h0000_0001; shcnt = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      c = 2;
      while (!done && c < 8) begin @(posedge clk); #1; c++; end
      check("ign_lat", 32'(c), 32'd3);
      check("ign_res", res, 32'hF800_0000);
      run_op("b2b_lsr", 2'b11, 32'h8000_0000, 5'd4, 32'h0800_0000, 2);

      // Reset during P2 of a ROR aborts it.
      op = 2'b10; value = 32'h1234_5678; shcnt = 5'd8; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_done", 32'(done), 32'd0);
      check("abort_res", res, 32'd0);
      check("abort_ready", 32'(ready), 32'd1);
      repeat (4) begin
         @(posedge clk); #1;
         check("abort_quiet", 32'(done), 32'd0);
      end
      run_op("post_rst", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 2);

      for (int i = 0; i < 10000; i++) begin
         ro = 2'($urandom);
         case ($urandom_range(0, 7))
            0:       rv = 32'h8000_0000;
            1:       rv = '1;
            2:       rv = 32'h7FFF_FFFF;
            default: rv = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       rn = 5'd0;
            1:       rn = 5'd31;
            default: rn = 5'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         run_op("rnd", ro, rv, rn, ref_res(ro, rv, rn), ref_lat(ro, rv));
      end

      repeat (3) @(posedge clk);
      #1;
      check("done_count", 32'(seen_dones), 32'(exp_dones));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
